// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage load/store unit: access-size encodings,
// FSM states, byte-strobe constants and address-alignment helpers.
package mem_pkg;

    localparam logic [2:0] LSHB_W  = 3'b000;
    localparam logic [2:0] LSHB_H  = 3'b001;
    localparam logic [2:0] LSHB_HU = 3'b010;
    localparam logic [2:0] LSHB_B  = 3'b011;
    localparam logic [2:0] LSHB_BU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_WORD = 4'b1111;
    localparam logic [3:0] STRB_HLO  = 4'b0011;
    localparam logic [3:0] STRB_HHI  = 4'b1100;
    localparam logic [3:0] STRB_BYTE = 4'b0001;

    // Byte offset after forcing natural alignment: words ignore both low bits,
    // halves keep only addr[1].
    function automatic logic [1:0] natural_off(input logic [2:0] lshb, input logic [1:0] a);
        case (lshb)
            LSHB_H, LSHB_HU: return {a[1], 1'b0};
            LSHB_B, LSHB_BU: return a;
            default:         return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] lshb, input logic [1:0] a);
        case (lshb)
            LSHB_H, LSHB_HU: return a[0];
            LSHB_B, LSHB_BU: return 1'b0;
            default:         return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the load/store unit (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          data_req;
    logic          data_wr;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_wdata;
    logic          data_ack;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_addr, data_wstrb, data_wdata,
        input  data_ack, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_addr, data_wstrb, data_wdata,
        output data_ack, data_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load alignment: shifts the addressed lane down and sign/zero-extends it.
module load_extend
    import mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    off,
    input  logic [2:0]    lshb,
    output logic [DW-1:0] ext
);
    logic [DW-1:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        ext = shifted;
        case (lshb)
            LSHB_H:  ext = {{(DW-16){shifted[15]}}, shifted[15:0]};
            LSHB_HU: ext = {{(DW-16){1'b0}},        shifted[15:0]};
            LSHB_B:  ext = {{(DW-8){shifted[7]}},   shifted[7:0]};
            LSHB_BU: ext = {{(DW-8){1'b0}},         shifted[7:0]};
            default: ext = shifted;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MIPS M-stage load/store unit: req/ack memory transaction with pipeline stall.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_EXC_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memtoregM,
    input  logic          memwriteM,
    input  logic [2:0]    lshbM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    mem_access_unit_if.master bus,
    output logic [DW-1:0] readdataM,
    output logic          stallM,
    output logic          addr_errM
);
    state_t        state, next_state;
    logic          op;
    logic          bad_in;
    logic [1:0]    off_in;
    logic [3:0]    strb_in;
    logic [DW-1:0] wdata_in;
    logic [AW-1:0] req_addr;
    logic          req_wr;
    logic [3:0]    req_wstrb;
    logic [DW-1:0] req_wdata;
    logic [2:0]    req_lshb;
    logic [1:0]    req_off;
    logic [DW-1:0] rdata_r;
    logic [DW-1:0] ext;

    assign op     = memtoregM | memwriteM;
    assign off_in = natural_off(lshbM, aluoutM[1:0]);

`ifdef MEM_ALIGN_EXC_EN
    logic err_r;

    assign bad_in = misaligned(lshbM, aluoutM[1:0]);

    always_ff @(posedge clk) begin
        if (rst)
            err_r <= 1'b0;
        else if (state == ST_IDLE && op)
            err_r <= bad_in;
    end

    assign addr_errM = (state == ST_DONE) && err_r;
`else
    assign bad_in    = 1'b0;
    assign addr_errM = 1'b0;
`endif

    // Reads carry no strobes, so a stray write can never be signalled.
    always_comb begin
        strb_in  = STRB_WORD;
        wdata_in = writedataM;
        case (lshbM)
            LSHB_H, LSHB_HU: begin
                strb_in  = off_in[1] ? STRB_HHI : STRB_HLO;
                wdata_in = {2{writedataM[15:0]}};
            end
            LSHB_B, LSHB_BU: begin
                strb_in  = STRB_BYTE << off_in;
                wdata_in = {4{writedataM[7:0]}};
            end
            default: ;
        endcase
        if (!memwriteM)
            strb_in = STRB_NONE;
    end

    always_comb begin
        next_state = state;
        stallM     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op) begin
                    stallM     = 1'b1;
                    next_state = bad_in ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stallM = 1'b1;
                if (bus.data_ack)
                    next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    load_extend #(.DW(DW)) u_load_extend (
        .rdata (bus.data_rdata),
        .off   (req_off),
        .lshb  (req_lshb),
        .ext   (ext)
    );

    // Request registers freeze the bus for the whole of WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_wr    <= 1'b0;
            req_wstrb <= STRB_NONE;
            req_wdata <= '0;
            req_lshb  <= LSHB_W;
            req_off   <= 2'b00;
            rdata_r   <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && op) begin
                req_addr  <= {aluoutM[AW-1:2], 2'b00};
                req_wr    <= memwriteM;
                req_wstrb <= strb_in;
                req_wdata <= wdata_in;
                req_lshb  <= lshbM;
                req_off   <= off_in;
                if (bad_in)
                    rdata_r <= '0;
            end
            if (state == ST_WAIT && bus.data_ack && !req_wr)
                rdata_r <= ext;
        end
    end

    assign bus.data_req   = (state == ST_WAIT);
    assign bus.data_wr    = (state == ST_WAIT) && req_wr;
    assign bus.data_wstrb = (state == ST_WAIT) ? req_wstrb : STRB_NONE;
    assign bus.data_addr  = req_addr;
    assign bus.data_wdata = req_wdata;
    assign readdataM      = rdata_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores, bus checks,
// stall-length checks and reset during an outstanding request.
module tb_mem_access_unit;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        is_load;
        logic [31:0] load_exp;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        memtoregM, memwriteM;
    logic [2:0]  lshbM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, addr_errM;

    txn_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 1;
    logic [31:0] mem_rdata = '0;
    logic        force_ack = 1'b0;
    logic        pend_rd = 1'b0;
    logic [31:0] pend_val = '0;

    mem_access_unit_if #(.AW(32), .DW(32)) bus ();

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .memtoregM  (memtoregM),
        .memwriteM  (memwriteM),
        .lshbM      (lshbM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .bus        (bus),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .addr_errM  (addr_errM)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acknowledges in the ack_delay-th cycle of a request.
    initial begin : memory_model
        int wait_cnt;
        wait_cnt = 0;
        bus.data_ack   = 1'b0;
        bus.data_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.data_ack = 1'b0;
            if (force_ack) begin
                bus.data_ack   = 1'b1;
                bus.data_rdata = 32'hFFFF_FFFF;
            end else if (bus.data_req) begin
                wait_cnt++;
                if (wait_cnt == ack_delay) begin
                    bus.data_ack   = 1'b1;
                    bus.data_rdata = mem_rdata;
                    wait_cnt       = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every request cycle must match the scoreboard head.
    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            if (pend_rd) begin
                checkOutput("readdataM", readdataM, pend_val);
                pend_rd = 1'b0;
            end
            if (bus.data_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req: got addr %h expected no request", bus.data_addr);
                end else begin
                    t = exp_q[0];
                    checkOutput("data_addr", bus.data_addr, t.addr);
                    checkOutput("data_wr", {31'b0, bus.data_wr}, {31'b0, t.wr});
                    checkOutput("data_wstrb", {28'b0, bus.data_wstrb}, {28'b0, t.strb});
                    if (t.wr)
                        checkOutput("data_wdata", bus.data_wdata, t.wdata);
                    if (bus.data_ack) begin
                        void'(exp_q.pop_front());
                        if (t.is_load) begin
                            pend_rd  = 1'b1;
                            pend_val = t.load_exp;
                        end
                    end
                end
            end
        end
    end

    task automatic applyStimulus(
        input logic mr, input logic mw, input logic [2:0] lshb,
        input logic [31:0] addr, input logic [31:0] wd,
        input int delay, input logic [31:0] rdata,
        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
        input logic [31:0] exp_load, input int exp_stall, input logic exp_err);
        int cnt;
        txn_t t;
        ack_delay = delay;
        mem_rdata = rdata;
        if ((mr || mw) && !exp_err) begin
            t.addr     = {addr[31:2], 2'b00};
            t.wr       = mw;
            t.strb     = exp_strb;
            t.wdata    = exp_wdata;
            t.is_load  = mr && !mw;
            t.load_exp = exp_load;
            exp_q.push_back(t);
        end
        memtoregM  = mr;
        memwriteM  = mw;
        lshbM      = lshb;
        aluoutM    = addr;
        writedataM = wd;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!stallM) break;
            cnt++;
            if (cnt >= 2) begin
                aluoutM    = ~addr;
                writedataM = ~wd;
                lshbM      = ~lshb;
            end
            if (cnt > 60) begin
                $display("[TB] FAIL stall_timeout: got %0d cycles expected %0d", cnt, exp_stall);
                break;
            end
        end
        checkOutput("stall_cycles", cnt, exp_stall);
        checkOutput("addr_errM", {31'b0, addr_errM}, {31'b0, exp_err});
        if (exp_err)
            checkOutput("err_readdataM", readdataM, 32'h0);
        @(posedge clk);
        #1;
        memtoregM = 1'b0;
        memwriteM = 1'b0;
    endtask

    task automatic resetInWait();
        txn_t t;
        ack_delay  = 1000;
        t.addr     = 32'h400;
        t.wr       = 1'b0;
        t.strb     = 4'b0000;
        t.wdata    = '0;
        t.is_load  = 1'b1;
        t.load_exp = '0;
        exp_q.push_back(t);
        memtoregM = 1'b1; memwriteM = 1'b0; lshbM = LSHB_W; aluoutM = 32'h400;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pre_req", {31'b0, bus.data_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        memtoregM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        checkOutput("rst_req", {31'b0, bus.data_req}, 32'h0);
        checkOutput("rst_stall", {31'b0, stallM}, 32'h0);
        checkOutput("rst_readdata", readdataM, 32'h0);
        checkOutput("rst_addr", bus.data_addr, 32'h0);
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        checkOutput("late_ack_stall", {31'b0, stallM}, 32'h0);
        checkOutput("late_ack_readdata", readdataM, 32'h0);
        checkOutput("late_ack_req", {31'b0, bus.data_req}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin : driver
        rst = 1'b1;
        memtoregM = 1'b0; memwriteM = 1'b0; lshbM = LSHB_W;
        aluoutM = '0; writedataM = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req", {31'b0, bus.data_req}, 32'h0);
        checkOutput("reset_stall", {31'b0, stallM}, 32'h0);
        checkOutput("reset_wstrb", {28'b0, bus.data_wstrb}, 32'h0);
        checkOutput("reset_wdata", bus.data_wdata, 32'h0);
        checkOutput("reset_readdata", readdataM, 32'h0);
        checkOutput("reset_err", {31'b0, addr_errM}, 32'h0);
        @(posedge clk); #1;

        //            mr  mw  lshb     addr      wd            d  rdata          strb     wdata          load           stall err
        applyStimulus(1, 0, LSHB_W,  32'h100, 32'h0,         2, 32'hDEADBEEF, 4'b0000, 32'h0,         32'hDEADBEEF, 3, 0);
        applyStimulus(1, 0, LSHB_B,  32'h103, 32'h0,         1, 32'h80112233, 4'b0000, 32'h0,         32'hFFFFFF80, 2, 0);
        applyStimulus(1, 0, LSHB_BU, 32'h103, 32'h0,         1, 32'h80112233, 4'b0000, 32'h0,         32'h00000080, 2, 0);
        applyStimulus(0, 1, LSHB_H,  32'h202, 32'h1234ABCD,  1, 32'h0,        4'b1100, 32'hABCDABCD,  32'h0,        2, 0);
        applyStimulus(0, 1, LSHB_B,  32'h301, 32'h000000A5,  3, 32'h0,        4'b0010, 32'hA5A5A5A5,  32'h0,        4, 0);
        applyStimulus(1, 0, LSHB_W,  32'h104, 32'h0,         1, 32'h01234567, 4'b0000, 32'h0,         32'h01234567, 2, 0);
        applyStimulus(0, 0, LSHB_W,  32'h500, 32'h0,         1, 32'h0,        4'b0000, 32'h0,         32'h0,        0, 0);
        applyStimulus(1, 0, LSHB_H,  32'h102, 32'h0,         2, 32'h80017FFF, 4'b0000, 32'h0,         32'hFFFF8001, 3, 0);
        applyStimulus(1, 0, LSHB_HU, 32'h100, 32'h0,         1, 32'h1234F00D, 4'b0000, 32'h0,         32'h0000F00D, 2, 0);
        applyStimulus(0, 1, LSHB_W,  32'h10C, 32'hCAFEF00D,  1, 32'h0,        4'b1111, 32'hCAFEF00D,  32'h0,        2, 0);
        applyStimulus(1, 1, LSHB_BU, 32'h003, 32'h00000077,  1, 32'h0,        4'b1000, 32'h77777777,  32'h0,        2, 0);
        applyStimulus(1, 0, LSHB_B,  32'h102, 32'h0,         1, 32'h007F0000, 4'b0000, 32'h0,         32'h0000007F, 2, 0);
        applyStimulus(1, 0, 3'b110,  32'h108, 32'h0,         1, 32'h89ABCDEF, 4'b0000, 32'h0,         32'h89ABCDEF, 2, 0);
`ifdef MEM_ALIGN_EXC_EN
        applyStimulus(1, 0, LSHB_W,  32'h102, 32'h0,         1, 32'h11223344, 4'b0000, 32'h0,         32'h0,        1, 1);
        applyStimulus(1, 0, LSHB_HU, 32'h103, 32'h0,         1, 32'hABCD0000, 4'b0000, 32'h0,         32'h0,        1, 1);
        applyStimulus(0, 1, LSHB_W,  32'h201, 32'h55667788,  1, 32'h0,        4'b1111, 32'h55667788,  32'h0,        1, 1);
`else
        applyStimulus(1, 0, LSHB_W,  32'h102, 32'h0,         1, 32'h11223344, 4'b0000, 32'h0,         32'h11223344, 2, 0);
        applyStimulus(1, 0, LSHB_HU, 32'h103, 32'h0,         1, 32'hABCD0000, 4'b0000, 32'h0,         32'h0000ABCD, 2, 0);
        applyStimulus(0, 1, LSHB_W,  32'h201, 32'h55667788,  1, 32'h0,        4'b1111, 32'h55667788,  32'h0,        2, 0);
`endif
        applyStimulus(1, 0, LSHB_W,  32'h110, 32'h0,         1, 32'h0BADF00D, 4'b0000, 32'h0,         32'h0BADF00D, 2, 0);

        resetInWait();

        applyStimulus(1, 0, LSHB_BU, 32'h101, 32'h0,         1, 32'h0000C300, 4'b0000, 32'h0,         32'h000000C3, 2, 0);

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit of the 5-stage MIPS pipeline.
- Consumes the M-stage control signals produced by the pipeline controller (memtoregM, memwriteM, lshbM) together with the datapath's ALU address and store data.
- Runs a req/ack transaction on the data-memory bus, generating byte strobes and replicated write data; load data is aligned and sign/zero-extended.
- Holds the pipeline through stallM until the access completes.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32, byte lanes = DW/8.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- memtoregM  in  1  M-stage load request.
- memwriteM  in  1  M-stage store request.
- lshbM  in  3  access size/sign: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 treated as word.
- aluoutM  in  AW  effective address.
- writedataM  in  DW  store data (rt).
- data_req  out  1  bus request.
- data_wr  out  1  1 = write, 0 = read.
- data_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00}).
- data_wstrb  out  4  byte enables; 0000 on reads.
- data_wdata  out  DW  lane-replicated store data.
- data_ack  in  1  bus completion; single-cycle pulse.
- data_rdata  in  DW  read data, valid with data_ack.
- readdataM  out  DW  extended load result.
- stallM  out  1  freeze IF..M stages.
- addr_errM  out  1  misaligned-access flag (only with the optional feature).

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- op = memtoregM | memwriteM. If both are asserted, the access is a store.
- IDLE:
  - If op is asserted, stallM = 1 combinationally, and the unit latches addr, wr, wstrb, wdata and lshbM into request registers.
  - Next state is WAIT. If no op, stays in IDLE with stallM = 0.
- WAIT:
  - data_req = 1, with bus outputs driven from the request registers; stallM = 1.
  - On data_ack, readdataM_r takes the extended data_rdata (stores leave it unchanged), and the next state is DONE.
  - No timeout; the unit waits indefinitely.
- DONE:
  - data_req = 0 and stallM = 0, so the pipeline advances at the end of this cycle.
  - readdataM is valid this cycle. Next state is IDLE.
  - An op in the following instruction is seen in the next IDLE cycle.
- Latency:
  - Minimum of 3 cycles per memory op (ack in the first WAIT cycle).
  - Each extra WAIT cycle adds one.
  - Non-memory instructions: 0 extra cycles.
- Strobes:
  - Word: 1111.
  - Half: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - Byte: 0001 << addr[1:0].
- Write data:
  - Word: writedataM.
  - Half: {2{wd[15:0]}}.
  - Byte: {4{wd[7:0]}}.
- Load extraction:
  - shifted = data_rdata >> (8*addr[1:0]). Half loads use addr[1] only.
  - Signed loads sign-extend bit 15 or bit 7; unsigned loads zero-extend.
- data_ack outside WAIT is ignored.
- Reset (including mid-transaction): state = IDLE; data_req, data_wr, stallM, addr_errM = 0; data_wstrb = 0000; data_addr, data_wdata, readdataM = 0. An abandoned transaction is not replayed.
- Outputs to the bus remain stable for the whole of WAIT, regardless of M-stage inputs.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - A misaligned access is one with a word and addr[1:0] != 00, or a half and addr[0] = 1.
  - In IDLE, such an access goes directly to DONE without a bus request.
  - addr_errM = 1 during that DONE cycle; readdataM = 0, and no write occurs.
- Undefined:
  - addr_errM is tied to 0.
  - Low address bits are ignored, so the access is forced to natural alignment (half uses addr[1], word uses neither).

Decomposition:
- Shared package mem_pkg:
  - lshb encodings (LSHB_W, LSHB_H, LSHB_HU, LSHB_B, LSHB_BU).
  - FSM state typedef/localparams.
  - Strobe constants.
- One natural sub-module, load_extend: combinational rdata/addr/lshb to extended word, reused by the verification model.

Test Plan:
- lw at 0x100, ack after 2 WAIT cycles, rdata 0xDEADBEEF: stallM high for 3 cycles, readdataM = 0xDEADBEEF in DONE, data_addr = 0x100, wstrb = 0000.
- lb at 0x103, rdata 0x80112233: readdataM = 0xFFFFFF80. lbu at the same address: 0x00000080.
- sh at 0x202, wd 0x1234ABCD: data_addr 0x200, wstrb 1100, wdata 0xABCDABCD, data_wr = 1.
- sb at 0x301, wd 0x000000A5: wstrb 0010, wdata 0xA5A5A5A5. Back-to-back sb then lw: two full transactions, no lost op.
- rst asserted in WAIT before ack: next cycle IDLE, data_req = 0, stallM = 0. A late ack is ignored and readdataM stays 0.
- With MEM_ALIGN_EXC_EN, lw at 0x102: no data_req, addr_errM = 1 for one cycle, stallM high for 1 cycle. Without the macro: read at 0x100.
